// File: rtl/ddr5_ctrl_pkg.sv
// rtl/ddr5_ctrl_pkg.sv - DDR5 command encoding, queue entry type and issue-queue FSM states
package ddr5_ctrl_pkg;

  // Entries carry the widest address any channel configuration uses; the queue slices it back down.
  localparam int ADDR_MAX_W = 32;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ACT = 4'd1,
    CMD_RD  = 4'd2,
    CMD_WR  = 4'd3,
    CMD_PRE = 4'd4,
    CMD_REF = 4'd5,
    CMD_MRS = 4'd6
  } cmd_type_e;

  typedef enum logic [1:0] {
    EMPTY,
    HEAD,
    BYPASS
  } iq_state_e;

  typedef struct packed {
    cmd_type_e             cmd;
    logic [4:0]            bank;
    logic [2:0]            bg;
    logic                  rank;
    logic [ADDR_MAX_W-1:0] addr;
    logic [7:0]            age;
  } queue_entry_t;

  function automatic logic is_bypassable(cmd_type_e c);
    return (c == CMD_RD) || (c == CMD_WR) || (c == CMD_PRE);
  endfunction

  function automatic logic is_barrier(cmd_type_e c);
    return (c == CMD_REF) || (c == CMD_MRS);
  endfunction

endpackage

// File: rtl/ddr5_bypass_picker.sv
// rtl/ddr5_bypass_picker.sv - finds the oldest RD/WR/PRE that may safely overtake the stalled head
import ddr5_ctrl_pkg::*;

module ddr5_bypass_picker #(
  parameter int DEPTH = 8
) (
  input  queue_entry_t             entries [DEPTH],
  input  logic [DEPTH-1:0]         valid,
  output logic                     candidate_found,
  output logic [$clog2(DEPTH)-1:0] candidate_idx
);

  localparam int IW = $clog2(DEPTH);

  // Walk from the tail down so the lowest qualifying index is the one left standing.
  always_comb begin
    candidate_found = 1'b0;
    candidate_idx   = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      logic hit;
      hit = valid[k] && is_bypassable(entries[k].cmd);
      for (int j = 0; j < DEPTH; j++) begin
        if (j < k && (is_barrier(entries[j].cmd) ||
                      {entries[j].rank, entries[j].bg, entries[j].bank} ==
                      {entries[k].rank, entries[k].bg, entries[k].bank})) begin
          hit = 1'b0;
        end
      end
      if (hit) begin
        candidate_found = 1'b1;
        candidate_idx   = IW'(k);
      end
    end
  end

  logic unused_fields;
  always_comb begin
    unused_fields = valid[0];
    for (int i = 0; i < DEPTH; i++) begin
      unused_fields = unused_fields ^ (^{entries[i].addr, entries[i].age});
    end
  end

endmodule

// File: rtl/ddr5_cmd_issue_queue.sv
// rtl/ddr5_cmd_issue_queue.sv - aging collapsing command queue feeding the hazard engine, with ACT bypass
import ddr5_ctrl_pkg::*;

module ddr5_cmd_issue_queue #(
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = 17,
  parameter int BYPASS_AFTER = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bypass_enable,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_cmd,
  input  logic [4:0]                   in_bank,
  input  logic [2:0]                   in_bg,
  input  logic                         in_rank,
  input  logic [ADDR_WIDTH-1:0]        in_addr,
  output logic                         req_valid,
  output logic [3:0]                   req_cmd,
  output logic [4:0]                   req_bank,
  output logic [2:0]                   req_bg,
  output logic                         req_rank,
  output logic [ADDR_WIDTH-1:0]        req_addr,
  output logic [7:0]                   req_priority,
  input  logic                         req_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [31:0]                  cnt_bypass_events
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = $clog2(BYPASS_AFTER + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [SW-1:0] STALL_MAX = SW'(BYPASS_AFTER);

  queue_entry_t      entries      [DEPTH];
  queue_entry_t      aged         [DEPTH+1];
  queue_entry_t      entries_next [DEPTH];
  queue_entry_t      new_entry;
  queue_entry_t      head;
  logic [DEPTH-1:0]  valid;
  logic [CW-1:0]     count, count_next, wr_pos;
  logic [IW-1:0]     sel_idx, sel_next, cand_idx;
  logic [SW-1:0]     stall_cnt, stall_next;
  iq_state_e         state, state_next;
  logic              cand_found, accept, push;

  assign in_ready  = count < DEPTH_C;
  assign occupancy = count;
  assign req_valid = state != EMPTY;
  assign accept    = req_valid && req_ready;
  // NOP completes the handshake but never occupies a slot.
  assign push      = in_valid && in_ready && (in_cmd != 4'(CMD_NOP));
  assign count_next = count + CW'(push) - CW'(accept);
  assign wr_pos     = count - CW'(accept);

  assign head         = entries[sel_idx];
  assign req_cmd      = req_valid ? head.cmd : 4'd0;
  assign req_bank     = req_valid ? head.bank : 5'd0;
  assign req_bg       = req_valid ? head.bg : 3'd0;
  assign req_rank     = req_valid && head.rank;
  assign req_addr     = req_valid ? head.addr[ADDR_WIDTH-1:0] : '0;
  assign req_priority = req_valid ? head.age : 8'd0;

  logic unused_addr_hi;
  assign unused_addr_hi = |(head.addr >> ADDR_WIDTH);

  always_comb begin
    new_entry      = '0;
    new_entry.cmd  = cmd_type_e'(in_cmd);
    new_entry.bank = in_bank;
    new_entry.bg   = in_bg;
    new_entry.rank = in_rank;
    new_entry.addr = ADDR_MAX_W'(in_addr);
  end

  // Age, collapse over the removed slot, then drop the new entry just past the survivors.
  always_comb begin
    aged[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = CW'(i) < count;
      aged[i]  = entries[i];
      if (valid[i] && entries[i].age != 8'hFF) aged[i].age = entries[i].age + 8'd1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && IW'(i) >= sel_idx) entries_next[i] = aged[i+1];
      else                             entries_next[i] = aged[i];
      if (push && CW'(i) == wr_pos)    entries_next[i] = new_entry;
    end
  end

  ddr5_bypass_picker #(.DEPTH(DEPTH)) u_picker (
    .entries         (entries),
    .valid           (valid),
    .candidate_found (cand_found),
    .candidate_idx   (cand_idx)
  );

  always_comb begin
    state_next = state;
    sel_next   = sel_idx;
    stall_next = stall_cnt;
    unique case (state)
      EMPTY: begin
        sel_next   = '0;
        stall_next = '0;
        if (count_next != '0) state_next = HEAD;
      end
      HEAD: begin
        sel_next = '0;
        if (accept) begin
          stall_next = '0;
          if (count_next == '0) state_next = EMPTY;
        end else begin
          if (stall_cnt != STALL_MAX) stall_next = stall_cnt + SW'(1);
          if (bypass_enable && entries[0].cmd == CMD_ACT &&
              stall_cnt == STALL_MAX && cand_found) begin
            state_next = BYPASS;
            sel_next   = cand_idx;
          end
        end
      end
      BYPASS: begin
        if (accept) begin
          stall_next = '0;
          sel_next   = '0;
          state_next = (count_next == '0) ? EMPTY : HEAD;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= EMPTY;
      sel_idx           <= '0;
      stall_cnt         <= '0;
      count             <= '0;
      cnt_bypass_events <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      state     <= state_next;
      sel_idx   <= sel_next;
      stall_cnt <= stall_next;
      count     <= count_next;
      for (int i = 0; i < DEPTH; i++) entries[i] <= entries_next[i];
      if (state == BYPASS && accept) cnt_bypass_events <= cnt_bypass_events + 32'd1;
    end
  end

endmodule

// File: tb/tb_ddr5_cmd_issue_queue.sv
// tb/tb_ddr5_cmd_issue_queue.sv - directed self-checking bench for ddr5_cmd_issue_queue
module tb_ddr5_cmd_issue_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bypass_enable = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cmd = 4'd0;
  logic [4:0]  in_bank = 5'd0;
  logic [2:0]  in_bg = 3'd0;
  logic        in_rank = 1'b0;
  logic [16:0] in_addr = 17'd0;
  logic        req_valid;
  logic [3:0]  req_cmd;
  logic [4:0]  req_bank;
  logic [2:0]  req_bg;
  logic        req_rank;
  logic [16:0] req_addr;
  logic [7:0]  req_priority;
  logic        req_ready = 1'b0;
  logic [3:0]  occupancy;
  logic [31:0] cnt_bypass_events;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] NOP = 4'd0, ACT = 4'd1, RD = 4'd2, WR = 4'd3, REF = 4'd5;

  ddr5_cmd_issue_queue #(.DEPTH(8), .ADDR_WIDTH(17), .BYPASS_AFTER(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .bypass_enable     (bypass_enable),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_cmd            (in_cmd),
    .in_bank           (in_bank),
    .in_bg             (in_bg),
    .in_rank           (in_rank),
    .in_addr           (in_addr),
    .req_valid         (req_valid),
    .req_cmd           (req_cmd),
    .req_bank          (req_bank),
    .req_bg            (req_bg),
    .req_rank          (req_rank),
    .req_addr          (req_addr),
    .req_priority      (req_priority),
    .req_ready         (req_ready),
    .occupancy         (occupancy),
    .cnt_bypass_events (cnt_bypass_events)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [4:0] b, input logic [16:0] a);
    in_valid = v;
    in_cmd   = c;
    in_bank  = b;
    in_addr  = a;
    in_bg    = 3'd0;
    in_rank  = 1'b0;
  endtask

  initial begin
    // reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_req_valid", req_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_cnt", cnt_bypass_events, 0);
    check("rst_req_cmd", req_cmd, 0);
    check("rst_req_prio", req_priority, 0);

    // NOP handshake completes but stores nothing
    drive(1, NOP, 0, 17'h1);
    tick();
    drive(0, NOP, 0, 0);
    check("nop_occupancy", occupancy, 0);
    check("nop_req_valid", req_valid, 0);

    // fill/drain with req_ready held high
    req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, RD, 5'd1, 17'(i));
      tick();
      check("fd_req_valid", req_valid, 1);
      check("fd_req_addr", req_addr, i);
      check("fd_req_cmd", req_cmd, RD);
      check("fd_occupancy", occupancy, 1);
    end
    drive(0, NOP, 0, 0);
    tick();
    check("fd_drained_occ", occupancy, 0);
    check("fd_drained_valid", req_valid, 0);
    req_ready = 1'b0;

    // aging of a single stalled ACT
    drive(1, ACT, 5'd2, 17'h100);
    tick();
    drive(0, NOP, 0, 0);
    check("age_0", req_priority, 8'h00);
    tick();
    check("age_1", req_priority, 8'h01);
    repeat (239) tick();
    check("age_240", req_priority, 8'hF0);
    repeat (15) tick();
    check("age_255", req_priority, 8'hFF);
    repeat (45) tick();
    check("age_sat", req_priority, 8'hFF);
    check("age_cmd", req_cmd, ACT);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("age_drain_occ", occupancy, 0);

    // bypass: ACT b3, RD b3, WR b7; WR is the only safe candidate
    bypass_enable = 1'b1;
    drive(1, ACT, 5'd3, 17'h1);
    tick();
    drive(1, RD, 5'd3, 17'h2);
    tick();
    drive(1, WR, 5'd7, 17'h3);
    tick();
    drive(0, NOP, 0, 0);
    tick();
    check("byp_head_act", req_cmd, ACT);
    repeat (4) tick();
    check("byp_cmd_wr", req_cmd, WR);
    check("byp_bank", req_bank, 7);
    check("byp_valid", req_valid, 1);
    req_ready = 1'b1;
    tick();
    check("byp_cnt", cnt_bypass_events, 1);
    check("byp_back_act", req_cmd, ACT);
    check("byp_occ2", occupancy, 2);
    tick();
    check("byp_then_rd", req_cmd, RD);
    check("byp_cnt_hold", cnt_bypass_events, 1);
    tick();
    check("byp_empty", occupancy, 0);
    req_ready = 1'b0;

    // barrier: REF between ACT and RD blocks any bypass
    drive(1, ACT, 5'd3, 17'h11);
    tick();
    drive(1, REF, 5'd0, 17'h12);
    tick();
    drive(1, RD, 5'd5, 17'h13);
    tick();
    drive(0, NOP, 0, 0);
    repeat (12) tick();
    check("bar_act", req_cmd, ACT);
    check("bar_addr", req_addr, 17'h11);
    req_ready = 1'b1;
    tick();
    check("bar_ref", req_cmd, REF);
    tick();
    check("bar_rd", req_cmd, RD);
    check("bar_cnt", cnt_bypass_events, 1);
    tick();
    check("bar_empty", occupancy, 0);
    req_ready = 1'b0;
    bypass_enable = 1'b0;

    // simultaneous enqueue/accept around full
    for (int i = 0; i < 8; i++) begin
      drive(1, RD, 5'd1, 17'(16 + i));
      tick();
      check("sim_fill_ready", in_ready, (i == 7) ? 1'b0 : 1'b1);
    end
    check("sim_full_occ", occupancy, 8);
    drive(1, RD, 5'd1, 17'h55);
    req_ready = 1'b1;
    tick();
    check("sim_refused_occ", occupancy, 7);
    check("sim_ready_back", in_ready, 1);
    check("sim_head17", req_addr, 17);
    drive(1, RD, 5'd1, 17'h66);
    tick();
    drive(0, NOP, 0, 0);
    check("sim_both_occ", occupancy, 7);
    check("sim_head18", req_addr, 18);
    repeat (6) tick();
    check("sim_slot6_addr", req_addr, 17'h66);
    check("sim_slot6_occ", occupancy, 1);
    tick();
    check("sim_empty", occupancy, 0);
    req_ready = 1'b0;

    // reset while in BYPASS
    bypass_enable = 1'b1;
    drive(1, ACT, 5'd3, 17'h21);
    tick();
    drive(1, RD, 5'd3, 17'h22);
    tick();
    drive(1, WR, 5'd7, 17'h23);
    tick();
    drive(0, NOP, 0, 0);
    repeat (5) tick();
    check("mid_byp_wr", req_cmd, WR);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", req_valid, 0);
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_cnt", cnt_bypass_events, 0);
    check("mid_rst_ready", in_ready, 1);
    drive(1, RD, 5'd4, 17'h1234);
    tick();
    drive(0, NOP, 0, 0);
    check("post_rst_addr", req_addr, 17'h1234);
    check("post_rst_occ", occupancy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr5_cmd_issue_queue.md
# ddr5_cmd_issue_queue

Per-channel command issue queue that sits directly upstream of the timing hazard engine. It buffers decoded DDR5 commands (ACT/RD/WR/PRE/REF/MRS) in arrival order and presents one command at a time on the hazard engine's `req_*` interface. It also ages each entry so the presented `req_priority` can trigger the hazard engine's starvation override. When the head ACT has stalled long enough, it can bypass that ACT with an older-safe RD/WR/PRE.

## Interface
- `DEPTH`, 8: queue entries (≥2).
- `ADDR_WIDTH`, 17: row/column address width.
- `BYPASS_AFTER`, 4: consecutive head-ACT stall cycles before a bypass is attempted (≥1).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bypass_enable`  in  1  permits ACT bypass; sampled every cycle.
- `in_valid`  in  1  enqueue request.
- `in_ready`  out  1  `count < DEPTH`.
- `in_cmd`  in  4  command code (NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5, MRS=6).
- `in_bank`  in  5  bank.
- `in_bg`  in  3  bank group.
- `in_rank`  in  1  rank.
- `in_addr`  in  ADDR_WIDTH  address.
- `req_valid`  out  1  presented entry is valid.
- `req_cmd`, `req_bank`, `req_bg`, `req_rank`, `req_addr`  out  4/5/3/1/ADDR_WIDTH  fields of the presented entry.
- `req_priority`  out  8  age of the presented entry.
- `req_ready`  in  1  hazard engine accepts the presented entry this cycle.
- `occupancy`  out  $clog2(DEPTH+1)  valid entry count.
- `cnt_bypass_events`  out  32  bypasses issued (accepted).

## Operation
- **Storage:** collapsing shift queue. Entry 0 is the oldest. Valid entries occupy slots 0..count-1.
- **Enqueue:** when `in_valid && in_ready`, the new entry is written with age 0 at slot count, or at slot count-1 if an entry is removed in the same cycle. Commands with `in_cmd` = NOP are dropped (not stored), but the handshake still completes.
- **Dequeue:** when `req_valid && req_ready`, entry sel_idx is removed. Slots sel_idx+1.. shift down by one in that same edge.
- **Aging:** every valid entry's age increments by 1 each cycle, saturating at 8'hFF. `req_priority` is the age of entry sel_idx.
- **FSM `state`:** values are EMPTY, HEAD, BYPASS.
  - EMPTY: count==0. `req_valid`=0, sel_idx=0. Moves to HEAD on the edge after the first enqueue.
  - HEAD: sel_idx=0. stall_cnt increments (saturating at BYPASS_AFTER) each cycle with `req_valid && !req_ready`, and clears on accept.
    - Go to BYPASS when all of these hold: `bypass_enable`, entry0.cmd==ACT, stall_cnt==BYPASS_AFTER, a candidate exists, and the head is not accepted this cycle. sel_idx is loaded with the candidate index.
  - BYPASS: sel_idx is held until accept; enqueues do not move it. On accept, go to HEAD (or EMPTY if the queue becomes empty) and clear stall_cnt.
- **Candidate:** the lowest k≥1 with cmd ∈ {RD, WR, PRE} such that no entry j<k has the same {rank, bg, bank}, and no entry j<k is REF or MRS (REF/MRS are barriers).
- Entry 0 never leaves except from HEAD, so ordering per bank is preserved.

## Timing
- Enqueue to `req_valid`: 1 cycle. No combinational in→req path.
- All `req_*` outputs are muxed from registers (entries, sel_idx). There is no combinational dependence on `req_ready` or `in_valid`.
- `in_ready` depends only on registered count. A full queue deasserts `in_ready` even if a dequeue happens in the same cycle.
- Head-stall to bypass presentation: BYPASS_AFTER stall cycles, then the candidate is presented the following cycle.
- The presented command may change while unaccepted only on the HEAD→BYPASS switch.
- `cnt_bypass_events` increments on each accept while in BYPASS, and wraps at 2^32.
- **Reset:** entries invalid, count=0, ages=0, state=EMPTY, stall_cnt=0, sel_idx=0, `req_valid`=0, all `req_*`=0, `in_ready`=1, `occupancy`=0, counter=0. A reset mid-operation discards all entries, with no partial dequeue.

## Structure
- Shared package `ddr5_ctrl_pkg`: cmd_type_e encoding (shared with the hazard engine) and the queue entry struct {cmd, bank, bg, rank, addr, age}.
- Sub-module `ddr5_bypass_picker` (combinational): takes the entry array plus valid vector, and returns candidate_found and candidate_idx.

## Test plan
- **Fill/drain:** enqueue 8 RDs with `req_ready`=1 → each presented 1 cycle after enqueue in order; `occupancy` peaks ≤8; `in_ready`=0 exactly when `occupancy`=8.
- **Aging:** hold `req_ready`=0 with one ACT queued for 300 cycles → `req_priority` counts 0,1,… and saturates at 8'hFF; reaches 8'hF0 at cycle 240.
- **Bypass:** queue ACT(bank 3), RD(bank 3), WR(bank 7), with `bypass_enable`=1 and `req_ready`=0. After 4 stall cycles the WR (bank 7) is presented, not the RD. Accept it → back to ACT; `cnt_bypass_events`=1.
- **Barrier:** queue ACT, REF, RD(other bank) → no bypass ever; ACT is presented until accepted.
- **Simultaneous:** full queue with accept of entry 0 and `in_valid`=1 → enqueue refused; next cycle `occupancy`=7 and `in_ready`=1. Then enqueue plus accept in the same cycle → `occupancy` stays 7 and the new entry lands at slot 6.
- **Reset mid-BYPASS:** assert `rst` for 1 cycle → next cycle `req_valid`=0, `occupancy`=0, state EMPTY, counter=0.
